// File: rtl/rocc_router_pkg.sv
// Shared constants and the response-buffer entry type for the RoCC command router.
package rocc_router_pkg;

    localparam int RD_W     = 5;
    localparam int FUNCT_W  = 7;
    localparam int CNT_W    = 4;
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [XLEN_MAX-1:0] data;
    } resp_entry_t;

endpackage

// File: rtl/rocc_rr_arbiter.sv
// N-way round-robin arbiter; the pointer moves past the winner only when its grant is accepted.
module rocc_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         i_req,
    input  logic                 i_accept,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_winner
);
    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    // N is a power of two, so the index wraps for free.
    always_comb begin
        o_grant  = '0;
        o_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = r_ptr + SEL_W'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = w_idx;
            end
        end
        if (w_found) o_grant[o_winner] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_ptr <= '0;
        else if (i_accept) r_ptr <= o_winner + SEL_W'(1);
    end

endmodule

// File: rtl/rocc_cmd_router.sv
// Routes RoCC commands to NUM_ACCEL accelerators and merges their responses (XLEN <= 64).
// Optional ROCC_ROUTER_ERR_EN: sticky protocol-error interrupt.
module rocc_cmd_router
    import rocc_router_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NUM_ACCEL = 4,
    parameter int MAX_OUT   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [FUNCT_W-1:0]        cmd_funct,
    input  logic [RD_W-1:0]           cmd_rd,
    input  logic                      cmd_xd,
    input  logic [XLEN-1:0]           cmd_rs1,
    input  logic [XLEN-1:0]           cmd_rs2,
    output logic [NUM_ACCEL-1:0]      acc_cmd_valid,
    input  logic [NUM_ACCEL-1:0]      acc_cmd_ready,
    output logic [FUNCT_W-1:0]        acc_cmd_funct,
    output logic [RD_W-1:0]           acc_cmd_rd,
    output logic                      acc_cmd_xd,
    output logic [XLEN-1:0]           acc_cmd_rs1,
    output logic [XLEN-1:0]           acc_cmd_rs2,
    input  logic [NUM_ACCEL-1:0]      acc_resp_valid,
    output logic [NUM_ACCEL-1:0]      acc_resp_ready,
    input  logic [RD_W*NUM_ACCEL-1:0] acc_resp_rd,
    input  logic [XLEN*NUM_ACCEL-1:0] acc_resp_data,
    input  logic [NUM_ACCEL-1:0]      acc_busy,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [RD_W-1:0]           resp_rd,
    output logic [XLEN-1:0]           resp_data,
    output logic                      busy,
    output logic                      interrupt
);
    localparam int SEL_W = $clog2(NUM_ACCEL);

    logic [CNT_W-1:0]     r_out_cnt [NUM_ACCEL];
    resp_entry_t          r_buf;
    logic                 r_buf_valid;

    logic [SEL_W-1:0]     w_tgt;
    logic                 w_stall;
    logic                 w_cmd_fire;
    logic [NUM_ACCEL-1:0] w_grant;
    logic [SEL_W-1:0]     w_winner;
    logic                 w_drain;
    logic                 w_load_ok;
    logic                 w_resp_fire;
    logic [NUM_ACCEL-1:0] w_inc;
    logic [NUM_ACCEL-1:0] w_dec;
    logic [NUM_ACCEL-1:0] w_cnt_zero;
    logic [NUM_ACCEL-1:0] w_cnt_full;
    resp_entry_t          w_entry;

    assign w_tgt   = cmd_funct[SEL_W-1:0];
    assign w_stall = cmd_xd && w_cnt_full[w_tgt];

    always_comb begin
        acc_cmd_valid        = '0;
        acc_cmd_valid[w_tgt] = cmd_valid & ~w_stall;
        cmd_ready            = acc_cmd_ready[w_tgt] & ~w_stall;
    end

    assign w_cmd_fire    = cmd_valid & cmd_ready;
    assign acc_cmd_funct = cmd_funct;
    assign acc_cmd_rd    = cmd_rd;
    assign acc_cmd_xd    = cmd_xd;
    assign acc_cmd_rs1   = cmd_rs1;
    assign acc_cmd_rs2   = cmd_rs2;

    rocc_rr_arbiter #(.N(NUM_ACCEL)) u_arb (
        .clock    (clock),
        .reset    (reset),
        .i_req    (acc_resp_valid),
        .i_accept (w_resp_fire),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    // The buffer can take a new response whenever it is empty or emptying this cycle.
    assign w_drain        = r_buf_valid & resp_ready;
    assign w_load_ok      = ~r_buf_valid | w_drain;
    assign acc_resp_ready = w_grant & {NUM_ACCEL{w_load_ok}};
    assign w_resp_fire    = |(acc_resp_valid & acc_resp_ready);

    always_comb begin
        w_entry.rd   = acc_resp_rd[w_winner*RD_W +: RD_W];
        w_entry.data = XLEN_MAX'(acc_resp_data[w_winner*XLEN +: XLEN]);
    end

    always_comb begin
        w_inc = '0;
        if (w_cmd_fire && cmd_xd) w_inc[w_tgt] = 1'b1;
        w_dec = acc_resp_valid & acc_resp_ready;
        for (int i = 0; i < NUM_ACCEL; i++) begin
            w_cnt_zero[i] = (r_out_cnt[i] == '0);
            w_cnt_full[i] = (r_out_cnt[i] == CNT_W'(MAX_OUT));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACCEL; i++) r_out_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ACCEL; i++) begin
                if (w_inc[i] && !w_dec[i] && !w_cnt_full[i])
                    r_out_cnt[i] <= r_out_cnt[i] + CNT_W'(1);
                else if (w_dec[i] && !w_inc[i] && !w_cnt_zero[i])
                    r_out_cnt[i] <= r_out_cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
            r_buf       <= '0;
        end else if (w_resp_fire) begin
            r_buf_valid <= 1'b1;
            r_buf       <= w_entry;
        end else if (w_drain) begin
            r_buf_valid <= 1'b0;
        end
    end

    assign resp_valid = r_buf_valid;
    assign resp_rd    = r_buf.rd;
    assign resp_data  = r_buf.data[XLEN-1:0];
    assign busy       = (|acc_busy) | (|(~w_cnt_zero)) | r_buf_valid;

`ifdef ROCC_ROUTER_ERR_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (|(w_dec & w_cnt_zero)) | (|(w_inc & ~w_dec & w_cnt_full));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          r_err <= 1'b0;
        else if (w_err_evt) r_err <= 1'b1;
    end

    assign interrupt = r_err;
`else
    assign interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_rocc_cmd_router.sv
// Directed bench for rocc_cmd_router (MAX_OUT=2) with a queue-based response scoreboard.
module tb_rocc_cmd_router;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [6:0]   cmd_funct;
    logic [4:0]   cmd_rd;
    logic         cmd_xd;
    logic [63:0]  cmd_rs1, cmd_rs2;
    logic [3:0]   acc_cmd_valid, acc_cmd_ready;
    logic [6:0]   acc_cmd_funct;
    logic [4:0]   acc_cmd_rd;
    logic         acc_cmd_xd;
    logic [63:0]  acc_cmd_rs1, acc_cmd_rs2;
    logic [3:0]   acc_resp_valid, acc_resp_ready;
    logic [19:0]  acc_resp_rd;
    logic [255:0] acc_resp_data;
    logic [3:0]   acc_busy;
    logic         resp_valid, resp_ready;
    logic [4:0]   resp_rd;
    logic [63:0]  resp_data;
    logic         busy, interrupt;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_irq;

    rocc_cmd_router #(.XLEN(64), .NUM_ACCEL(4), .MAX_OUT(2)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
        .cmd_rd(cmd_rd), .cmd_xd(cmd_xd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
        .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rd(acc_cmd_rd), .acc_cmd_xd(acc_cmd_xd),
        .acc_cmd_rs1(acc_cmd_rs1), .acc_cmd_rs2(acc_cmd_rs2),
        .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
        .acc_resp_rd(acc_resp_rd), .acc_resp_data(acc_resp_data), .acc_busy(acc_busy),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_data(resp_data), .busy(busy), .interrupt(interrupt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Scoreboard monitor: every response the core takes must match the queue head.
    always @(negedge clock) begin
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected actual rd=%0d data=%h required none", resp_rd, resp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rd", 64'(resp_rd), 64'(e.rd));
                chk("resp_data", resp_data, e.data);
            end
        end
    end

    task automatic send_cmd(input logic [6:0] f, input logic xd, input logic [4:0] rd);
        bit ok;
        ok        = 1'b0;
        cmd_funct = f;
        cmd_xd    = xd;
        cmd_rd    = rd;
        cmd_rs1   = 64'h100 + 64'(f);
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (cmd_ready) ok = 1'b1;
            @(posedge clock);
            #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_resp(input int idx, input logic [4:0] rd, input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        acc_resp_rd[idx*5 +: 5]     = rd;
        acc_resp_data[idx*64 +: 64] = d;
        acc_resp_valid[idx]         = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (acc_resp_ready[idx]) ok = 1'b1;
            @(posedge clock);
            #1;
        end
        acc_resp_valid[idx] = 1'b0;
        if (ok) sb.push_back('{rd, d});
        chk("resp_accept", 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ROCC_ROUTER_ERR_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        reset = 1'b1;
        cmd_valid = 0; cmd_funct = 0; cmd_rd = 0; cmd_xd = 0; cmd_rs1 = 0; cmd_rs2 = 0;
        acc_cmd_ready = 0; acc_resp_valid = 0; acc_resp_rd = 0; acc_resp_data = 0;
        acc_busy = 0; resp_ready = 1'b1;

        @(negedge clock);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_interrupt", 64'(interrupt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_acc_resp_ready", 64'(acc_resp_ready), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // xd command to accelerator 2
        acc_cmd_ready = 4'b0100;
        cmd_funct = 7'h02; cmd_xd = 1'b1; cmd_rd = 5'd3; cmd_rs1 = 64'hCAFE; cmd_rs2 = 64'hF00D;
        cmd_valid = 1'b1;
        @(negedge clock);
        chk("route_valid", 64'(acc_cmd_valid), 64'b0100);
        chk("route_ready", 64'(cmd_ready), 64'd1);
        chk("route_rs1", acc_cmd_rs1, 64'hCAFE);
        chk("route_rd", 64'(acc_cmd_rd), 64'd3);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("busy_outstanding", 64'(busy), 64'd1);
        tick(1);
        send_resp(2, 5'd3, 64'h1111);
        tick(2);
        @(negedge clock);
        chk("busy_idle", 64'(busy), 64'd0);
        tick(1);

        // stall at MAX_OUT on accelerator 1
        acc_cmd_ready = 4'b0010;
        send_cmd(7'h01, 1'b1, 5'd1);
        send_cmd(7'h01, 1'b1, 5'd2);
        cmd_funct = 7'h01; cmd_xd = 1'b1; cmd_rd = 5'd3; cmd_valid = 1'b1;
        @(negedge clock);
        chk("stall_ready", 64'(cmd_ready), 64'd0);
        chk("stall_valid", 64'(acc_cmd_valid), 64'd0);
        @(posedge clock); #1;
        acc_resp_rd[5 +: 5] = 5'd4; acc_resp_data[64 +: 64] = 64'h4444; acc_resp_valid[1] = 1'b1;
        @(negedge clock);
        chk("stall_resp_ready", 64'(acc_resp_ready), 64'b0010);
        chk("stall_hold", 64'(cmd_ready), 64'd0);
        @(posedge clock); #1;
        sb.push_back('{5'd4, 64'h4444});
        acc_resp_valid[1] = 1'b0;
        @(negedge clock);
        chk("stall_release", 64'(cmd_ready), 64'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);

        // round-robin with all requesters held
        acc_cmd_ready = 4'b1111;
        send_cmd(7'h00, 1'b1, 5'd0);
        send_cmd(7'h00, 1'b1, 5'd0);
        send_cmd(7'h01, 1'b1, 5'd0);
        send_cmd(7'h02, 1'b1, 5'd0);
        send_cmd(7'h03, 1'b1, 5'd0);
        for (int i = 0; i < 4; i++) begin
            acc_resp_rd[i*5 +: 5]     = 5'(10 + i);
            acc_resp_data[i*64 +: 64] = 64'hA0 + 64'(i);
        end
        acc_resp_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (c % 4);
            @(negedge clock);
            chk("rr_grant", 64'(acc_resp_ready), 64'(exp_g));
            if (c > 0) chk("rr_resp_valid", 64'(resp_valid), 64'd1);
            sb.push_back('{5'(10 + (c % 4)), 64'hA0 + 64'(c % 4)});
            @(posedge clock); #1;
        end
        acc_resp_valid = 4'b0000;
        @(negedge clock);
        chk("rr_resp_valid_last", 64'(resp_valid), 64'd1);
        tick(2);
        @(negedge clock);
        chk("rr_busy_idle", 64'(busy), 64'd0);
        tick(1);

        // backpressure hold
        send_cmd(7'h01, 1'b1, 5'd9);
        send_cmd(7'h02, 1'b1, 5'd6);
        resp_ready = 1'b0;
        acc_resp_rd[5 +: 5] = 5'd9; acc_resp_data[64 +: 64] = 64'hDEAD; acc_resp_valid[1] = 1'b1;
        @(negedge clock);
        chk("bp_first_ready", 64'(acc_resp_ready), 64'b0010);
        @(posedge clock); #1;
        sb.push_back('{5'd9, 64'hDEAD});
        acc_resp_valid[1] = 1'b0;
        acc_resp_rd[10 +: 5] = 5'd6; acc_resp_data[128 +: 64] = 64'h2222; acc_resp_valid[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_rd", 64'(resp_rd), 64'd9);
            chk("bp_data", resp_data, 64'hDEAD);
            chk("bp_acc_ready", 64'(acc_resp_ready), 64'd0);
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(negedge clock);
        chk("bp_drain_ready", 64'(acc_resp_ready), 64'b0100);
        sb.push_back('{5'd6, 64'h2222});
        @(posedge clock); #1;
        acc_resp_valid[2] = 1'b0;
        tick(3);

        // response with nothing outstanding
        send_resp(3, 5'd7, 64'h77);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("err_interrupt", 64'(interrupt), 64'(exp_irq));
            @(posedge clock); #1;
        end

        // reset while buffer is full and accel 0 has two outstanding
        send_cmd(7'h01, 1'b1, 5'd2);
        resp_ready = 1'b0;
        send_resp(1, 5'd2, 64'hBEEF);
        send_cmd(7'h00, 1'b1, 5'd1);
        send_cmd(7'h00, 1'b1, 5'd1);
        @(negedge clock);
        chk("pre_rst_valid", 64'(resp_valid), 64'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1 chk("async_rst_valid", 64'(resp_valid), 64'd0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        chk("post_rst_valid", 64'(resp_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_interrupt", 64'(interrupt), 64'd0);
        @(posedge clock); #1;
        acc_busy = 4'b1000;
        @(negedge clock);
        chk("post_rst_acc_busy", 64'(busy), 64'd1);
        @(posedge clock); #1;
        acc_busy = 4'b0000;
        resp_ready = 1'b1;
        send_cmd(7'h00, 1'b1, 5'd1);
        tick(3);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
